// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: keeps a fetch PC, issues in-order memory reads and buffers the
// returned instructions in a small prefetch queue presented to the decoder over valid/ready.
module instruction_fetch_unit #(
  parameter int                         ADDRESS_WIDTH     = 32,
  parameter int                         INSTRUCTION_WIDTH = 16,
  parameter int                         FIFO_DEPTH        = 4,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC          = '0
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          take_i,
  input  logic [ADDRESS_WIDTH-1:0]      branch_target_i,
  output logic                          mem_request_o,
  output logic [ADDRESS_WIDTH-1:0]      mem_address_o,
  input  logic                          mem_grant_i,
  input  logic                          mem_rvalid_i,
  input  logic [INSTRUCTION_WIDTH-1:0]  mem_rdata_i,
  output logic                          instruction_valid_o,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction_o,
  output logic [ADDRESS_WIDTH-1:0]      instruction_pc_o,
  input  logic                          decode_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] insn;
    logic [ADDRESS_WIDTH-1:0]     pc;
  } entry_t;

  entry_t                  fifo_q [FIFO_DEPTH];
  entry_t                  head;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           outst_q, outst_d;
  logic [CW-1:0]           discard_q, discard_d;
  logic [CW:0]             inflight;
  logic                    flush, grant_fire, push, pop, dropping;

  assign flush    = enable_i & take_i;
  assign inflight = {1'b0, count_q} + {1'b0, outst_q};
  assign dropping = (discard_q != '0);

  // Gated by reset so the request line reads 0 while reset is held.
  assign mem_request_o = reset_i & enable_i & ~take_i & (inflight < (CW+1)'(FIFO_DEPTH));
  assign mem_address_o = fetch_pc_q;
  assign grant_fire    = mem_request_o & mem_grant_i;

  assign push = mem_rvalid_i & ~flush & ~dropping;
  assign pop  = instruction_valid_o & decode_ready_i & enable_i & ~flush;

  assign head                = fifo_q[rd_ptr_q];
  assign instruction_valid_o = (count_q != '0);
  assign instruction_o       = instruction_valid_o ? head.insn : '0;
  assign instruction_pc_o    = instruction_valid_o ? head.pc   : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q + CW'(grant_fire) - CW'(mem_rvalid_i);
    discard_d  = discard_q;
    if (flush) begin
      fetch_pc_d = branch_target_i;
      resp_pc_d  = branch_target_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // Every read still in flight after this cycle belongs to the old stream,
      // including any already marked for dropping by an earlier flush.
      discard_d  = outst_q - CW'(mem_rvalid_i);
    end else begin
      if (grant_fire) fetch_pc_d = fetch_pc_q + 1'b1;
      if (push) begin
        resp_pc_d = resp_pc_q + 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (mem_rvalid_i && dropping) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{insn: mem_rdata_i, pc: resp_pc_q};
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit with a latency-configurable in-order memory model.
module tb_instruction_fetch_unit;

  localparam int AW = 32;
  localparam int IW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, take, gnt, ready;
  logic [AW-1:0] tgt;
  logic          mem_req, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_rdata;
  logic          ivalid;
  logic [IW-1:0] insn;
  logic [AW-1:0] ipc;

  int n_chk  = 0;
  int n_fail = 0;
  int grants = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [AW-1:0] expq [$];

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } mreq_t;
  mreq_t mq [$];

  logic          snap_gfire, snap_rv;
  logic [AW-1:0] snap_addr;

  instruction_fetch_unit #(
    .ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .FIFO_DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en), .take_i(take), .branch_target_i(tgt),
    .mem_request_o(mem_req), .mem_address_o(mem_addr), .mem_grant_i(gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .instruction_valid_o(ivalid), .instruction_o(insn), .instruction_pc_o(ipc),
    .decode_ready_i(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] memval(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3C3;
  endfunction

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: in-order, response exactly lat cycles after grant (later ones slip by a cycle).
  always @(negedge clk) begin
    snap_gfire = mem_req & gnt & rst_n;
    snap_addr  = mem_addr;
    snap_rv    = mem_rvalid;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      mq.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end else begin
      if (snap_rv && mq.size() > 0) void'(mq.pop_front());
      if (snap_gfire) begin
        mq.push_back('{a: snap_addr, due: cyc - 1 + lat});
        grants++;
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memval(mq[0].a);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // Monitor: every accepted head is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ivalid && ready && en && !take) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h, scoreboard empty", ipc);
        end else begin
          logic [AW-1:0] e;
          e = expq.pop_front();
          chk("head_pc", ipc, e);
          chk("head_insn", {16'h0, insn}, {16'h0, memval(e)});
        end
      end else if (!ivalid) begin
        chk("empty_insn_zero", {16'h0, insn}, '0);
        chk("empty_pc_zero", ipc, '0);
      end
      if (mem_rvalid && !(en && take) && dut.discard_q == '0) begin
        n_chk++;
        if (dut.count_q == 3'(DEPTH) && !(ivalid && ready && en)) begin
          n_fail++;
          $display("FAIL push_into_full: count %0d", dut.count_q);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int l, input logic r);
    chk("scoreboard_drained", expq.size(), 0);
    rst_n = 1'b0;
    take  = 1'b0;
    tgt   = '0;
    en    = 1'b1;
    ready = r;
    lat   = l;
    tick();
    tick();
    grants = 0;
    rst_n  = 1'b1;
  endtask

  task automatic finish_stream(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      sample();
      if (expq.size() == 0) break;
    end
    if (i == max) begin
      n_chk++;
      n_fail++;
      $display("FAIL stream_timeout: %0d entries left, expected 0", expq.size());
      expq.delete();
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_mem_request"}, {31'h0, mem_req}, 0);
    chk({tag, "_mem_address"}, mem_addr, 0);
    chk({tag, "_valid"}, {31'h0, ivalid}, 0);
    chk({tag, "_insn"}, {16'h0, insn}, 0);
    chk({tag, "_pc"}, ipc, 0);
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; en = 1'b1; take = 1'b0; tgt = '0; gnt = 1'b1; ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    reset_outputs("reset");

    // 1: streaming from PC 0, first head within 3 cycles
    start(1, 1'b1);
    for (int i = 0; i < 8; i++) expq.push_back(AW'(i));
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      if (ivalid) begin found = 1'b1; break; end
    end
    chk("first_valid_latency", {31'h0, found}, 1);
    finish_stream(40);

    // 2: stalled consumer fills exactly DEPTH, one pop frees one request
    start(1, 1'b0);
    expq.push_back(0);
    repeat (10) tick();
    sample();
    chk("stall_grants", grants, 4);
    chk("stall_no_request", {31'h0, mem_req}, 0);
    chk("stall_head_pc", ipc, 0);
    chk("stall_head_insn", {16'h0, insn}, {16'h0, memval(0)});
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    sample();
    chk("refill_request", {31'h0, mem_req}, 1);
    chk("refill_address", mem_addr, 4);
    repeat (5) tick();
    sample();
    chk("refill_grants", grants, 5);
    chk("refill_full_again", {31'h0, mem_req}, 0);
    chk("refill_head_pc", ipc, 1);

    // 3: branch with two reads outstanding
    start(3, 1'b1);
    for (int i = 0; i < 3; i++) expq.push_back(32'h40 + AW'(i));
    tick();
    tick();
    take = 1'b1; tgt = 32'h40;
    sample();
    chk("take_blocks_request", {31'h0, mem_req}, 0);
    tick();
    take = 1'b0;
    sample();
    chk("redirect_address", mem_addr, 32'h40);
    finish_stream(40);

    // 4: branch coinciding with a response and a pop
    start(2, 1'b1);
    for (int i = 0; i < 3; i++) expq.push_back(32'h100 + AW'(i));
    tick(); tick(); tick();
    take = 1'b1; tgt = 32'h100;
    sample();
    chk("t4_no_request", {31'h0, mem_req}, 0);
    chk("t4_head_before_flush", {31'h0, ivalid}, 1);
    tick();
    take = 1'b0;
    sample();
    chk("t4_queue_flushed", {31'h0, ivalid}, 0);
    chk("t4_redirect_address", mem_addr, 32'h100);
    finish_stream(40);

    // 5: enable low with two outstanding; take ignored while disabled
    start(3, 1'b1);
    tick();
    tick();
    en = 1'b0;
    sample();
    chk("disabled_no_request", {31'h0, mem_req}, 0);
    tick();
    take = 1'b1; tgt = 32'h77;
    tick();
    take = 1'b0;
    tick();
    tick();
    sample();
    chk("disabled_head_valid", {31'h0, ivalid}, 1);
    chk("disabled_head_pc", ipc, 0);
    chk("disabled_grants", grants, 2);
    chk("disabled_take_ignored", mem_addr, 2);
    for (int i = 0; i < 5; i++) expq.push_back(AW'(i));
    tick();
    en = 1'b1;
    finish_stream(40);

    // 6: address wrap, then reset in the middle of streaming
    start(1, 1'b1);
    take = 1'b1; tgt = 32'hFFFF_FFFF;
    expq.push_back(32'hFFFF_FFFF);
    expq.push_back(32'h0);
    expq.push_back(32'h1);
    tick();
    take = 1'b0;
    sample();
    chk("wrap_top_address", mem_addr, 32'hFFFF_FFFF);
    tick();
    sample();
    chk("wrap_to_zero", mem_addr, 0);
    finish_stream(40);
    #3;
    rst_n = 1'b0;
    #1;
    reset_outputs("midreset");

    // 7: back-to-back branches
    start(3, 1'b1);
    for (int i = 0; i < 3; i++) expq.push_back(32'h300 + AW'(i));
    tick();
    tick();
    take = 1'b1; tgt = 32'h200;
    tick();
    tgt = 32'h300;
    tick();
    take = 1'b0;
    sample();
    chk("b2b_retarget_address", mem_addr, 32'h300);
    finish_stream(40);

    chk("scoreboard_final", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
